// File: rtl/esc_rx_responder_pkg.sv
// Types and constants local to the escalation receiver.
package esc_rx_responder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CHECK  = 2'b01,
        ESC    = 2'b10,
        SIGINT = 2'b11
    } esc_rx_state_e;

endpackage

// File: rtl/prim_esc_pkg.sv
// Differential escalation wire types shared between the alert handler sender and its receivers.
package prim_esc_pkg;

    typedef struct packed {
        logic esc_p;
        logic esc_n;
    } esc_tx_t;

    typedef struct packed {
        logic resp_p;
        logic resp_n;
    } esc_rx_t;

endpackage

// File: rtl/esc_diff_decode.sv
// Combinational classifier for a differential pair: valid high level, valid idle, or
// a signal-integrity fault when both wires agree.
module esc_diff_decode (
    input  logic diff_p,
    input  logic diff_n,
    output logic lvl,
    output logic idle,
    output logic sigint
);

    assign lvl    = diff_p & ~diff_n;
    assign idle   = ~diff_p & diff_n;
    assign sigint = diff_p ~^ diff_n;

endmodule

// File: rtl/esc_rx_responder.sv
// Escalation receiver: answers pings, raises esc_en_o on sustained escalation and
// reflects differential faults back to the sender. All outputs are registered.
//
// state  | meaning
// IDLE   | wires idle, resp=(0,1)
// CHECK  | first high cycle seen; ping or escalation not yet known
// ESC    | escalation sustained, esc_en_o high, resp_p toggling
// SIGINT | esc_p == esc_n, both response wires toggle together
module esc_rx_responder
    import prim_esc_pkg::*;
    import esc_rx_responder_pkg::*;
#(
    parameter int unsigned PingCntW = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  esc_tx_t             esc_tx_i,
    output esc_rx_t             esc_rx_o,
    output logic                esc_en_o,
    output logic                sigint_o,
    input  logic                ping_cnt_clr_i,
    output logic [PingCntW-1:0] ping_cnt_o
);

    localparam logic [PingCntW-1:0] PingCntOne = PingCntW'(1);
    localparam logic [PingCntW-1:0] PingCntMax = '1;

    logic lvl;
    logic idle;
    logic sigint;

    esc_rx_state_e state_q;
    esc_rx_state_e state_d;

    logic resp_p_q, resp_n_q, esc_en_q, sigint_q;
    logic resp_p_d, resp_n_d, esc_en_d, sigint_d;
    logic ping_done;
    logic [PingCntW-1:0] ping_cnt_q;

    esc_diff_decode u_decode (
        .diff_p (esc_tx_i.esc_p),
        .diff_n (esc_tx_i.esc_n),
        .lvl    (lvl),
        .idle   (idle),
        .sigint (sigint)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sigint) begin
            state_d = SIGINT;
        end else begin
            case (state_q)
                IDLE:    if (lvl) state_d = CHECK;
                CHECK:   if (lvl) state_d = ESC;
                         else if (idle) state_d = IDLE;
                ESC:     if (idle) state_d = IDLE;
                SIGINT:  if (lvl) state_d = CHECK;
                         else if (idle) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; idle response (0,1) is the default.
    always_comb begin
        resp_p_d  = 1'b0;
        resp_n_d  = 1'b1;
        esc_en_d  = 1'b0;
        sigint_d  = 1'b0;
        ping_done = 1'b0;
        if (sigint) begin
            resp_p_d = ~resp_p_q;
            resp_n_d = ~resp_p_q;
            sigint_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lvl) begin
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end
                end
                CHECK: begin
                    if (lvl) begin
                        esc_en_d = 1'b1;
                    end else if (idle) begin
                        ping_done = 1'b1;
                    end
                end
                ESC: begin
                    if (lvl) begin
                        resp_p_d = ~resp_p_q;
                        resp_n_d = resp_p_q;
                        esc_en_d = 1'b1;
                    end
                end
                SIGINT: begin
                    if (lvl) begin
                        resp_p_d = 1'b1;
                        resp_n_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_p_q   <= 1'b0;
            resp_n_q   <= 1'b1;
            esc_en_q   <= 1'b0;
            sigint_q   <= 1'b0;
            ping_cnt_q <= '0;
        end else begin
            resp_p_q <= resp_p_d;
            resp_n_q <= resp_n_d;
            esc_en_q <= esc_en_d;
            sigint_q <= sigint_d;
            // Clear beats a coincident ping; count saturates rather than wrapping.
            if (ping_cnt_clr_i) begin
                ping_cnt_q <= '0;
            end else if (ping_done && ping_cnt_q != PingCntMax) begin
                ping_cnt_q <= ping_cnt_q + PingCntOne;
            end
        end
    end

    assign esc_rx_o.resp_p = resp_p_q;
    assign esc_rx_o.resp_n = resp_n_q;
    assign esc_en_o        = esc_en_q;
    assign sigint_o        = sigint_q;
    assign ping_cnt_o      = ping_cnt_q;

endmodule
